// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared FND display types, codes and helpers
package fnd_pkg;

    localparam logic [3:0] BLANK_CODE     = 4'hF;
    localparam int         DEFAULT_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        FORMAT
    } conv_state_t;

    // Largest value representable in the given number of decimal digits.
    function automatic longint unsigned max_bcd_value(input int digits);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - shift-and-add-3 correction for one BCD nibble
module bcd_digit_adjust (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // Inputs never exceed 9, so the sum stays within 4 bits (max 12).
    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_encoder.sv
// rtl/bin_to_bcd_encoder.sv - sequential binary-to-BCD encoder with blanking and overflow
module bin_to_bcd_encoder
    import fnd_pkg::*;
#(
    parameter int BIN_W    = 14,
    parameter int DIGITS   = DEFAULT_DIGITS,
    parameter int LZ_BLANK = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_bin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_overflow
);

    localparam int              CNT_W   = $clog2(BIN_W + 1);
    localparam int              BCD_W   = 4 * DIGITS;
    localparam longint unsigned MAX_VAL = max_bcd_value(DIGITS);

    conv_state_t        state;
    conv_state_t        state_nxt;
    logic               accept;
    logic [BIN_W-1:0]   shift_reg;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   scratch_adj;
    logic [BCD_W-1:0]   bcd_fmt;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_flag;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    accept    = 1'b1;
                    state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = FORMAT;
                end
            end
            FORMAT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_busy = (state != IDLE);

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (scratch[4*g +: 4]),
            .adjusted (scratch_adj[4*g +: 4])
        );
    end

    // Leading zeros above the highest nonzero digit are blanked; digit 0 always shows.
    always_comb begin
        logic leading;
        bcd_fmt = scratch;
        leading = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (leading && (scratch[4*k +: 4] == 4'd0)) begin
                if (LZ_BLANK != 0) begin
                    bcd_fmt[4*k +: 4] = BLANK_CODE;
                end
            end else begin
                leading = 1'b0;
            end
        end
        if (ovf_flag) begin
            bcd_fmt = {DIGITS{BLANK_CODE}};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
            o_bcd      <= {DIGITS{BLANK_CODE}};
            shift_reg  <= '0;
            scratch    <= '0;
            cnt        <= '0;
            ovf_flag   <= 1'b0;
        end else begin
            state  <= state_nxt;
            o_done <= 1'b0;
            if (accept) begin
                shift_reg <= i_bin;
                scratch   <= '0;
                cnt       <= CNT_W'(BIN_W);
                ovf_flag  <= (64'(i_bin) > MAX_VAL);
            end
            // Carries out of the top nibble are dropped; overflow was decided at capture.
            if (state == CONVERT) begin
                scratch   <= {scratch_adj[BCD_W-2:0], shift_reg[BIN_W-1]};
                shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
                cnt       <= cnt - CNT_W'(1);
            end
            if (state == FORMAT) begin
                o_bcd      <= bcd_fmt;
                o_overflow <= ovf_flag;
                o_done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_encoder.sv
// tb/tb_bin_to_bcd_encoder.sv - self-checking bench for bin_to_bcd_encoder
module tb_bin_to_bcd_encoder;

    localparam int BIN_W   = 14;
    localparam int LATENCY = BIN_W + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin = '0;

    logic        busy_lz, done_lz, ovf_lz;
    logic [15:0] bcd_lz;
    logic        busy_nz, done_nz, ovf_nz;
    logic [15:0] bcd_nz;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    bin_to_bcd_encoder #(.BIN_W(14), .DIGITS(4), .LZ_BLANK(1)) dut_lz (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_bin(bin),
        .o_busy(busy_lz), .o_done(done_lz), .o_bcd(bcd_lz), .o_overflow(ovf_lz)
    );

    bin_to_bcd_encoder #(.BIN_W(14), .DIGITS(4), .LZ_BLANK(0)) dut_nz (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_bin(bin),
        .o_busy(busy_nz), .o_done(done_nz), .o_bcd(bcd_nz), .o_overflow(ovf_nz)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal formatting straight from the value, digit by digit.
    function automatic logic [15:0] model_bcd(input int v, input bit lz);
        logic [15:0] r;
        int p;
        int d;
        if (v > 9999) return 16'hFFFF;
        r = '0;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            d = (v / p) % 10;
            if (lz && k > 0 && v < p) d = 15;
            r[4*k +: 4] = 4'(d);
            p = p * 10;
        end
        return r;
    endfunction

    // Cycle-level model: remaining busy cycles, then results on the done cycle.
    int          m_left = 0;
    int          m_val = 0;
    logic        m_done = 1'b0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_bcd_lz = 16'hFFFF;
    logic [15:0] m_bcd_nz = 16'hFFFF;

    always @(posedge clk) begin
        if (reset) begin
            m_left   <= 0;
            m_done   <= 1'b0;
            m_ovf    <= 1'b0;
            m_bcd_lz <= 16'hFFFF;
            m_bcd_nz <= 16'hFFFF;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    m_val  <= int'(bin);
                    m_left <= LATENCY - 1;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done   <= 1'b1;
                    m_ovf    <= (m_val > 9999);
                    m_bcd_lz <= model_bcd(m_val, 1'b1);
                    m_bcd_nz <= model_bcd(m_val, 1'b0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy_lz", 32'(busy_lz), 32'(m_left != 0));
            check("busy_nz", 32'(busy_nz), 32'(m_left != 0));
            check("done_lz", 32'(done_lz), 32'(m_done));
            check("done_nz", 32'(done_nz), 32'(m_done));
            check("bcd_lz",  32'(bcd_lz),  32'(m_bcd_lz));
            check("bcd_nz",  32'(bcd_nz),  32'(m_bcd_nz));
            check("ovf_lz",  32'(ovf_lz),  32'(m_ovf));
            check("ovf_nz",  32'(ovf_nz),  32'(m_ovf));
        end
    end

    task automatic pulse_start(input int v);
        @(negedge clk);
        start = 1'b1;
        bin   = 14'(v);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called one negedge after the start cycle; returns cycles from start to done.
    task automatic wait_done(output int n);
        n = 1;
        while (!done_lz && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic convert(input int v, input logic [15:0] exp_lz, input logic [15:0] exp_nz,
                           input logic exp_ovf);
        int n;
        pulse_start(v);
        wait_done(n);
        check("latency", 32'(n), 32'(LATENCY));
        check("lit_bcd_lz", 32'(bcd_lz), 32'(exp_lz));
        check("lit_bcd_nz", 32'(bcd_nz), 32'(exp_nz));
        check("lit_ovf", 32'(ovf_lz), 32'(exp_ovf));
    endtask

    initial begin
        int n;
        bit seen_done;

        repeat (2) @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;

        seen_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done_lz) seen_done = 1'b1;
        end
        check("idle_bcd", 32'(bcd_lz), 32'h0000FFFF);
        check("idle_busy", 32'(busy_lz), 32'h0);
        check("idle_no_done", 32'(seen_done), 32'h0);

        convert(1234,  16'h1234, 16'h1234, 1'b0);
        convert(42,    16'hFF42, 16'h0042, 1'b0);
        convert(0,     16'hFFF0, 16'h0000, 1'b0);
        convert(9999,  16'h9999, 16'h9999, 1'b0);
        convert(10000, 16'hFFFF, 16'hFFFF, 1'b1);
        convert(5,     16'hFFF5, 16'h0005, 1'b0);
        convert(16383, 16'hFFFF, 16'hFFFF, 1'b1);
        convert(1000,  16'h1000, 16'h1000, 1'b0);

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd1234;
        @(negedge clk);
        start = 1'b0;
        bin   = 14'd7777;
        repeat (3) @(negedge clk);
        start = 1'b1;
        bin   = 14'd5678;
        @(negedge clk);
        start = 1'b0;
        n = 5;
        while (!done_lz && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ignored_latency", 32'(n), 32'(LATENCY));
        check("ignored_bcd", 32'(bcd_lz), 32'h00001234);
        start = 1'b1;
        bin   = 14'd5678;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("b2b_latency", 32'(n), 32'(LATENCY));
        check("b2b_bcd", 32'(bcd_lz), 32'h00005678);

        // Reset mid-conversion aborts without a done pulse.
        pulse_start(1234);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy_lz), 32'h0);
        check("abort_bcd", 32'(bcd_lz), 32'h0000FFFF);
        check("abort_ovf", 32'(ovf_lz), 32'h0);
        seen_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done_lz || done_nz) seen_done = 1'b1;
        end
        check("abort_no_done", 32'(seen_done), 32'h0);

        convert(807, 16'hF807, 16'h0807, 1'b0);

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
